// File: rtl/lsu_pipe_if.sv
// Core-side op handshake and system-bus signals of the load/store unit.
// The LSU connects through the slave modport; the core/bus environment uses the master modport.
interface lsu_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  i_VALID;
  logic                  i_WE;
  logic [ADDR_W-1:0]     i_ADDR;
  logic [DATA_W-1:0]     i_WDATA;
  logic [1:0]            i_HB;
  logic                  i_ULOAD;
  logic                  o_READY;
  logic                  o_DONE;
  logic                  o_ERR;
  logic [DATA_W-1:0]     o_RDATA;
  logic                  o_BUS_REQ;
  logic                  i_BUS_GNT;
  logic [ADDR_W-1:0]     o_BUS_ADDR;
  logic [DATA_W-1:0]     o_BUS_WDATA;
  logic [DATA_W/8-1:0]   o_BUS_BE;
  logic                  o_BUS_WE;
  logic                  o_BUS_RE;
  logic [DATA_W-1:0]     i_BUS_RDATA;
  logic                  i_BUS_ACK;

  modport slave (
    input  i_VALID, i_WE, i_ADDR, i_WDATA, i_HB, i_ULOAD,
    input  i_BUS_GNT, i_BUS_RDATA, i_BUS_ACK,
    output o_READY, o_DONE, o_ERR, o_RDATA,
    output o_BUS_REQ, o_BUS_ADDR, o_BUS_WDATA, o_BUS_BE, o_BUS_WE, o_BUS_RE
  );

  modport master (
    output i_VALID, i_WE, i_ADDR, i_WDATA, i_HB, i_ULOAD,
    output i_BUS_GNT, i_BUS_RDATA, i_BUS_ACK,
    input  o_READY, o_DONE, o_ERR, o_RDATA,
    input  o_BUS_REQ, o_BUS_ADDR, o_BUS_WDATA, o_BUS_BE, o_BUS_WE, o_BUS_RE
  );
endinterface

// File: rtl/lsu_pipe.sv
// Sequential load/store unit: one op at a time, bus request/grant, ack with timeout,
// lane-aligned store data/byte enables and lane-shifted, extended load data.
module lsu_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       i_CLK,
  input  logic       i_RSTn,
  lsu_pipe_if.slave  bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_e;

  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                capture;
  logic                active;

  logic                we_q;
  logic                uload_q;
  logic [1:0]          hb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LB-1:0]       lane;

  assign lane = addr_q[LB-1:0];

  function automatic logic is_illegal(input logic [1:0] hb, input logic [ADDR_W-1:0] a);
    case (hb)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = a[0];
      2'b10:   is_illegal = |a[1:0];
      default: is_illegal = (DATA_W == 32) || (|a[2:0]);
    endcase
  endfunction

  function automatic logic [NB-1:0] be_mask(input logic [1:0] hb, input logic [LB-1:0] l);
    logic [NB-1:0] base;
    case (hb)
      2'b00:   base = NB'(8'h01);
      2'b01:   base = NB'(8'h03);
      2'b10:   base = NB'(8'h0F);
      default: base = NB'(8'hFF);
    endcase
    be_mask = base << l;
  endfunction

  // Every lane carries a copy so the slave can pick whichever lanes BE enables.
  function automatic logic [DATA_W-1:0] lane_rep(input logic [1:0] hb, input logic [DATA_W-1:0] w);
    case (hb)
      2'b00:   lane_rep = {NB{w[7:0]}};
      2'b01:   lane_rep = {(DATA_W/16){w[15:0]}};
      2'b10:   lane_rep = {(DATA_W/32){w[31:0]}};
      default: lane_rep = w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [1:0] hb, input logic u,
                                                 input logic [LB-1:0] l,
                                                 input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] keep;
    logic              sgn;
    sh = rd >> {l, 3'b000};
    case (hb)
      2'b00:   begin keep = DATA_W'(8'hFF);         sgn = sh[7];  end
      2'b01:   begin keep = DATA_W'(16'hFFFF);      sgn = sh[15]; end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); sgn = sh[31]; end
      default: begin keep = '1;                     sgn = 1'b0;   end
    endcase
    sgn = sgn & ~u;
    load_ext = (sh & keep) | (~keep & {DATA_W{sgn}});
  endfunction

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Op fields are only meaningful once captured, so they carry no reset.
  always_ff @(posedge i_CLK) begin
    if (capture) begin
      we_q    <= bus.i_WE;
      uload_q <= bus.i_ULOAD;
      hb_q    <= bus.i_HB;
      addr_q  <= bus.i_ADDR;
      wdata_q <= bus.i_WDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = '0;
    rdata_d = rdata_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_VALID) begin
          capture = 1'b1;
          if (is_illegal(bus.i_HB, bus.i_ADDR)) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = REQ;
            err_d   = 1'b0;
          end
        end
      end
      REQ: begin
        if (bus.i_BUS_GNT) state_d = XFER;
      end
      XFER: begin
        cnt_d = cnt_q + CW'(1);
        // ACK takes priority over an expiring timeout in the same cycle.
        if (bus.i_BUS_ACK) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (!we_q) rdata_d = load_ext(hb_q, uload_q, lane, bus.i_BUS_RDATA);
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign active          = (state_q == REQ) || (state_q == XFER);
  assign bus.o_READY     = (state_q == IDLE);
  assign bus.o_DONE      = (state_q == RESP);
  assign bus.o_ERR       = (state_q == RESP) && err_q;
  assign bus.o_RDATA     = rdata_q;
  assign bus.o_BUS_REQ   = active;
  assign bus.o_BUS_ADDR  = active ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign bus.o_BUS_WDATA = active ? lane_rep(hb_q, wdata_q) : '0;
  assign bus.o_BUS_BE    = active ? be_mask(hb_q, lane) : '0;
  assign bus.o_BUS_WE    = active && we_q;
  assign bus.o_BUS_RE    = active && !we_q;
endmodule

// File: tb/tb_lsu_pipe.sv
// Bench for lsu_pipe (32-bit data, TIMEOUT=4): directed plan cases plus random ops
// checked against an arithmetic model of alignment, lanes and extension.
module tb_lsu_pipe;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] hold_rdata = '0;

  lsu_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  lsu_pipe #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input int bytes, input int lane);
    logic [7:0] m;
    m = 8'((1 << bytes) - 1) << lane;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] w, input int bits);
    logic [63:0] v;
    logic [63:0] r;
    v = {32'd0, w} & ((64'd1 << bits) - 64'd1);
    r = '0;
    for (int k = 0; k < 32; k += bits) r = r | (v << k);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] rd, input int lane, input int bits,
                                       input logic u);
    logic [63:0] v;
    v = ({32'd0, rd} >> (8 * lane)) & ((64'd1 << bits) - 64'd1);
    if (!u && v[bits-1]) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic chk_bus(input string ph, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    chk({ph, "_req"},   bus.o_BUS_REQ, 1'b1);
    chk({ph, "_addr"},  bus.o_BUS_ADDR, addr & 32'hFFFF_FFFC);
    chk({ph, "_be"},    bus.o_BUS_BE, be);
    chk({ph, "_we"},    bus.o_BUS_WE, we);
    chk({ph, "_re"},    bus.o_BUS_RE, !we);
    if (we) chk({ph, "_wdata"}, bus.o_BUS_WDATA, wd);
    chk({ph, "_ready"}, bus.o_READY, 1'b0);
    chk({ph, "_done"},  bus.o_DONE, 1'b0);
  endtask

  task automatic drive_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] hb, input logic u);
    bus.i_VALID = 1'b1;
    bus.i_WE    = we;
    bus.i_ADDR  = addr;
    bus.i_WDATA = wdata;
    bus.i_HB    = hb;
    bus.i_ULOAD = u;
    @(negedge clk);
    bus.i_VALID = 1'b0;
    bus.i_WE    = 1'($urandom);
    bus.i_ADDR  = $urandom;
    bus.i_WDATA = $urandom;
    bus.i_HB    = 2'($urandom);
    bus.i_ULOAD = 1'($urandom);
  endtask

  // ack_cyc: XFER cycle (1-based) carrying ACK; beyond TO means the slave never answers.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] hb, input logic u, input int gnt_dly,
                       input int ack_cyc, input logic [31:0] rd);
    int   bytes;
    int   lane;
    bit   illegal;
    bit   acked;
    logic [31:0] exp_rd;
    bytes   = 1 << hb;
    lane    = int'(addr[1:0]);
    illegal = (bytes > 4) || ((addr % bytes) != 0);
    chk("idle_ready", bus.o_READY, 1'b1);
    drive_op(we, addr, wdata, hb, u);
    acked = 1'b0;
    if (!illegal) begin
      for (int g = 0; g <= gnt_dly; g++) begin
        chk_bus("req", we, addr, m_be(bytes, lane), m_wd(wdata, 8 * bytes));
        bus.i_BUS_GNT = (g == gnt_dly);
        @(negedge clk);
        bus.i_BUS_GNT = 1'b0;
      end
      for (int c = 1; c <= TO; c++) begin
        chk_bus("xfer", we, addr, m_be(bytes, lane), m_wd(wdata, 8 * bytes));
        if (c == ack_cyc) begin
          bus.i_BUS_ACK   = 1'b1;
          bus.i_BUS_RDATA = rd;
        end
        @(negedge clk);
        bus.i_BUS_ACK   = 1'b0;
        bus.i_BUS_RDATA = $urandom;
        if (c == ack_cyc) begin
          acked = 1'b1;
          break;
        end
      end
    end
    if (!acked) exp_rd = '0;
    else if (!we) exp_rd = m_ld(rd, lane, 8 * bytes, u);
    else exp_rd = hold_rdata;
    hold_rdata = exp_rd;
    chk("resp_done",  bus.o_DONE, 1'b1);
    chk("resp_err",   bus.o_ERR, !acked);
    chk("resp_rdata", bus.o_RDATA, exp_rd);
    chk("resp_req",   bus.o_BUS_REQ, 1'b0);
    chk("resp_strb",  {bus.o_BUS_WE, bus.o_BUS_RE}, 2'b00);
    chk("resp_be",    bus.o_BUS_BE, 4'h0);
    chk("resp_ready", bus.o_READY, 1'b0);
    @(negedge clk);
    chk("after_done",  bus.o_DONE, 1'b0);
    chk("after_ready", bus.o_READY, 1'b1);
    chk("after_hold",  bus.o_RDATA, hold_rdata);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, bus.o_READY, 1'b1);
    chk({tag, "_done"},  bus.o_DONE, 1'b0);
    chk({tag, "_err"},   bus.o_ERR, 1'b0);
    chk({tag, "_req"},   bus.o_BUS_REQ, 1'b0);
    chk({tag, "_strb"},  {bus.o_BUS_WE, bus.o_BUS_RE}, 2'b00);
    chk({tag, "_be"},    bus.o_BUS_BE, 4'h0);
    chk({tag, "_addr"},  bus.o_BUS_ADDR, 32'h0);
    chk({tag, "_wdata"}, bus.o_BUS_WDATA, 32'h0);
    chk({tag, "_rdata"}, bus.o_RDATA, 32'h0);
  endtask

  initial begin
    bus.i_VALID = 1'b0; bus.i_WE = 1'b0; bus.i_ADDR = '0; bus.i_WDATA = '0;
    bus.i_HB = 2'b00; bus.i_ULOAD = 1'b0;
    bus.i_BUS_GNT = 1'b0; bus.i_BUS_ACK = 1'b0; bus.i_BUS_RDATA = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word load, grant after 2 waits: DONE lands 5 cycles after accept.
    do_op(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 2, 1, 32'hDEADBEEF);
    chk("tp_word", bus.o_RDATA, 32'hDEADBEEF);
    do_op(1'b0, 32'h1003, 32'h0, 2'b00, 1'b0, 0, 1, 32'h80FFFFFF);
    chk("tp_sbyte", bus.o_RDATA, 32'hFFFFFF80);
    do_op(1'b0, 32'h1003, 32'h0, 2'b00, 1'b1, 0, 1, 32'h80FFFFFF);
    chk("tp_ubyte", bus.o_RDATA, 32'h00000080);
    do_op(1'b0, 32'h1002, 32'h0, 2'b01, 1'b0, 1, 2, 32'h8001_1234);
    chk("tp_shalf", bus.o_RDATA, 32'hFFFF8001);
    do_op(1'b1, 32'h2002, 32'h0000ABCD, 2'b01, 1'b0, 1, 3, 32'h0);
    do_op(1'b0, 32'h3001, 32'h0, 2'b10, 1'b0, 0, 1, 32'h0);
    chk("tp_misalign_rdata", bus.o_RDATA, 32'h0);
    do_op(1'b0, 32'h3000, 32'h0, 2'b11, 1'b0, 0, 1, 32'h0);
    do_op(1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, 0, TO + 5, 32'h0);
    do_op(1'b0, 32'h4004, 32'h0, 2'b10, 1'b0, 0, TO, 32'h1234_5678);
    chk("tp_ack_at_timeout", bus.o_RDATA, 32'h12345678);

    // Reset during XFER: outputs fall to reset values at once, no DONE follows.
    drive_op(1'b0, 32'h5000, 32'h0, 2'b10, 1'b0);
    bus.i_BUS_GNT = 1'b1;
    @(negedge clk);
    bus.i_BUS_GNT = 1'b0;
    chk("rst_in_xfer", bus.o_BUS_REQ, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    hold_rdata = '0;
    @(negedge clk);
    chk("post_rst_done", bus.o_DONE, 1'b0);
    do_op(1'b0, 32'h5008, 32'h0, 2'b10, 1'b1, 0, 1, 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  hb;
      hb = 2'($urandom_range(3));
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(3) != 0) a = a & ~((32'd1 << hb) - 32'd1);
      do_op(1'($urandom), a, $urandom, hb, 1'($urandom), $urandom_range(3),
            $urandom_range(1, TO + 2), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
